// File: rtl/ram_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ram_port_arbiter_pkg
//   Shared types and defaults for the message-RAM port arbiter.
//   - owner_e  : which requester a RAM read belongs to (host / modem)
//   - state_e  : arbitration mode (idle round-robin / transmit priority)
//   - rd_tag_t : entry of the read-return tag pipeline
// ----------------------------------------------------------------------------
package ram_port_arbiter_pkg;

   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 8;

   typedef enum logic {
      OWN_HOST  = 1'b0,
      OWN_MODEM = 1'b1
   } owner_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_TX   = 1'b1
   } state_e;

   typedef struct packed {
      logic   vld;
      owner_e own;
   } rd_tag_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// ram_port_arbiter_if
//   Bundles every signal between the arbiter, its two requesters and the RAM.
//   modport slave  : arbiter view (requests/RAM read data in, grants/RAM cmd out)
//   modport master : environment view (control, signal_gen, RAM macro)
//   Host port  : h_req/h_we/h_addr/h_wdata -> h_gnt/h_err/h_rvalid/h_rdata
//   Modem port : m_req/m_addr              -> m_gnt/m_rvalid/m_rdata
//   RAM port   : ram_en/ram_we/ram_addr/ram_wdata <- ram_rdata
//   tx_active  : modem transmission in progress (selects arbitration mode)
// ----------------------------------------------------------------------------
interface ram_port_arbiter_if
   import ram_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              tx_active;

   logic              h_req;
   logic              h_we;
   logic [ADDR_W-1:0] h_addr;
   logic [DATA_W-1:0] h_wdata;
   logic              h_gnt;
   logic              h_err;
   logic              h_rvalid;
   logic [DATA_W-1:0] h_rdata;

   logic              m_req;
   logic [ADDR_W-1:0] m_addr;
   logic              m_gnt;
   logic              m_rvalid;
   logic [DATA_W-1:0] m_rdata;

   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  tx_active,
      input  h_req, h_we, h_addr, h_wdata,
      output h_gnt, h_err, h_rvalid, h_rdata,
      input  m_req, m_addr,
      output m_gnt, m_rvalid, m_rdata,
      output ram_en, ram_we, ram_addr, ram_wdata,
      input  ram_rdata
   );

   modport master (
      output tx_active,
      output h_req, h_we, h_addr, h_wdata,
      input  h_gnt, h_err, h_rvalid, h_rdata,
      output m_req, m_addr,
      input  m_gnt, m_rvalid, m_rdata,
      input  ram_en, ram_we, ram_addr, ram_wdata,
      output ram_rdata
   );

endinterface

// File: rtl/ram_port_arbiter_rd_tag_pipe.sv
// ----------------------------------------------------------------------------
// ram_rd_tag_pipe
//   Shift register of {valid, owner} that follows each RAM read from grant to
//   data return, steering the read-data-valid strobe to the right requester.
//   Stage 0 is loaded at the end of the grant cycle (alongside the registered
//   RAM command); the last stage lines up with RAM read data.
//   Ports: clk, reset_n (async low), push (tag of this cycle's grant),
//          h_rvalid / m_rvalid (read data valid for host / modem).
// ----------------------------------------------------------------------------
module ram_rd_tag_pipe
   import ram_port_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk,
   input  logic    reset_n,
   input  rd_tag_t push,
   output logic    h_rvalid,
   output logic    m_rvalid
);

   logic [DEPTH-1:0] vld_pipe;
   owner_e           own_pipe [DEPTH];

   // Clearing valid bits on reset drops every read still in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe <= '0;
         for (int i = 0; i < DEPTH; i++) own_pipe[i] <= OWN_HOST;
      end else begin
         vld_pipe[0] <= push.vld;
         own_pipe[0] <= push.own;
         for (int i = 1; i < DEPTH; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            own_pipe[i] <= own_pipe[i-1];
         end
      end
   end

   assign h_rvalid = vld_pipe[DEPTH-1] & (own_pipe[DEPTH-1] == OWN_HOST);
   assign m_rvalid = vld_pipe[DEPTH-1] & (own_pipe[DEPTH-1] == OWN_MODEM);

endmodule

// File: rtl/ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// ram_port_arbiter
//   Shares the single-port message RAM between the SPI host port (read/write)
//   and the modem reader (read only).
//   - Idle (tx_active=0): round-robin on conflict, lone requester wins.
//   - Transmit: modem wins conflicts; a host that has lost STARVE_MAX
//     consecutive cycles wins once. Host writes are acknowledged with h_err
//     and never reach the RAM, so the frame being sent cannot change.
//   Grants are combinational in the request cycle; the RAM command is
//   registered and appears the cycle after. Read data is returned
//   RD_LATENCY cycles after the command with the owner's rvalid strobe.
//   Ports: clk, reset_n (async low), bus (ram_port_arbiter_if.slave).
// ----------------------------------------------------------------------------
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int RD_LATENCY = 1,
   parameter int STARVE_MAX = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   ram_port_arbiter_if.slave      bus
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   state_e            state;
   owner_e            last_winner;
   logic [CNT_W-1:0]  starve_cnt;

   logic              host_win;
   logic              host_gnt;
   logic              modem_gnt;
   logic              wr_reject;
   logic              issue;
   logic [ADDR_W-1:0] addr_nxt;
   rd_tag_t           tag_push;
   logic              h_rv;
   logic              m_rv;

   // ---------------------------------------------------------------------
   // Arbitration uses the registered mode, so a tx_active edge only changes
   // the policy from the following cycle.
   // ---------------------------------------------------------------------
   always_comb begin
      host_win = 1'b0;
      if (bus.h_req && bus.m_req) begin
         if (state == ST_TX)
            host_win = (starve_cnt == CNT_W'(STARVE_MAX));
         else
            host_win = (last_winner == OWN_MODEM);
      end else begin
         host_win = bus.h_req;
      end
   end

   // Grants are gated by reset so nothing is acknowledged while held in reset.
   assign host_gnt  = reset_n & bus.h_req & host_win;
   assign modem_gnt = reset_n & bus.m_req & ~host_win;
   assign wr_reject = host_gnt & bus.h_we & (state == ST_TX);
   assign issue     = (host_gnt & ~wr_reject) | modem_gnt;
   assign addr_nxt  = host_gnt ? bus.h_addr : bus.m_addr;

   assign tag_push.vld = modem_gnt | (host_gnt & ~bus.h_we);
   assign tag_push.own = host_gnt ? OWN_HOST : OWN_MODEM;

   assign bus.h_gnt = host_gnt;
   assign bus.m_gnt = modem_gnt;
   assign bus.h_err = wr_reject;

   // ---------------------------------------------------------------------
   // Mode FSM, fairness state and registered RAM command.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         last_winner   <= OWN_MODEM;
         starve_cnt    <= '0;
         bus.ram_en    <= 1'b0;
         bus.ram_we    <= 1'b0;
         bus.ram_addr  <= '0;
         bus.ram_wdata <= '0;
      end else begin
         state <= bus.tx_active ? ST_TX : ST_IDLE;

         // A rejected write still counts as a host grant for fairness.
         if (host_gnt)
            last_winner <= OWN_HOST;
         else if (modem_gnt)
            last_winner <= OWN_MODEM;

         // Counts only consecutive host losses while transmitting.
         if (state == ST_IDLE || !bus.h_req || host_gnt)
            starve_cnt <= '0;
         else if (starve_cnt != CNT_W'(STARVE_MAX))
            starve_cnt <= starve_cnt + CNT_W'(1);

         bus.ram_en <= issue;
         bus.ram_we <= host_gnt & bus.h_we & ~wr_reject;

         // Address/data hold their last values on idle cycles.
         if (issue)
            bus.ram_addr <= addr_nxt;
         if (host_gnt && bus.h_we && !wr_reject)
            bus.ram_wdata <= bus.h_wdata;
      end
   end

   // ---------------------------------------------------------------------
   // Read return: tag stage 0 lines up with the command, so RD_LATENCY more
   // stages bring it to the cycle the RAM presents data.
   // ---------------------------------------------------------------------
   ram_rd_tag_pipe #(
      .DEPTH (RD_LATENCY + 1)
   ) u_tag_pipe (
      .clk      (clk),
      .reset_n  (reset_n),
      .push     (tag_push),
      .h_rvalid (h_rv),
      .m_rvalid (m_rv)
   );

   assign bus.h_rvalid = h_rv;
   assign bus.m_rvalid = m_rv;
   assign bus.h_rdata  = h_rv ? bus.ram_rdata : {DATA_W{1'b0}};
   assign bus.m_rdata  = m_rv ? bus.ram_rdata : {DATA_W{1'b0}};

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single 1024x8 message RAM between two requesters: the SPI host port (control block; read and write) and the modem reader (signal generator; read only).
- Sits between control, signal_gen and the RAM macro, and replaces ad-hoc address/enable muxing.
- Policy depends on tx_active:
  - idle: round-robin;
  - transmitting: modem has priority with bounded host starvation, and host writes are locked out so message contents cannot change mid-frame.

Parameters:
ADDR_W, 10, RAM address width
DATA_W, 8, RAM data width
RD_LATENCY, 1, RAM read latency in cycles from registered command (legal 1..2)
STARVE_MAX, 8, consecutive lost cycles after which a waiting host wins once while transmitting

Ports:
clk  in  1  single clock for arbiter and RAM
reset_n  in  1  asynchronous active-low reset
tx_active  in  1  modem transmission in progress
h_req  in  1  host request; held with h_we/h_addr/h_wdata stable until h_gnt
h_we  in  1  host write (1) / read (0)
h_addr  in  ADDR_W  host address
h_wdata  in  DATA_W  host write data
h_gnt  out  1  host request accepted this cycle
h_err  out  1  pulses with h_gnt when a write is rejected
h_rvalid  out  1  host read data valid
h_rdata  out  DATA_W  host read data
m_req  in  1  modem read request; held with m_addr stable until m_gnt
m_addr  in  ADDR_W  modem address
m_gnt  out  1  modem request accepted this cycle
m_rvalid  out  1  modem read data valid
m_rdata  out  DATA_W  modem read data
ram_en  out  1  RAM access enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM=IDLE, last_winner=MODEM (host wins the first tie), starve_cnt=0, tag pipeline cleared.
- Handshake:
  - h_gnt/m_gnt are combinational, in the same cycle N as the accepted request.
  - At most one gnt per cycle. A requester may present a new request in the cycle after its gnt.
- Command timing:
  - ram_en/ram_we/ram_addr/ram_wdata are registered and valid in cycle N+1.
  - ram_en=0 in cycles with no grant.
  - When ram_en=0, ram_addr/ram_wdata hold their last values.
- Read return:
  - A tag shift register (depth RD_LATENCY+1) carries owner and read flag.
  - For reads, the owner's rvalid is high in cycle N+1+RD_LATENCY, with rdata=ram_rdata in that cycle.
  - Writes produce no rvalid. rdata is don't-care when rvalid=0.
- FSM IDLE (tx_active=0):
  - Round-robin: with both requesting, the winner is the one not equal to last_winner.
  - A single requester wins immediately. last_winner updates on every grant.
  - starve_cnt is held at 0.
- FSM TX (tx_active=1):
  - The modem wins any conflict. Each cycle the host requests and loses, starve_cnt increments.
  - When starve_cnt==STARVE_MAX and h_req=1, the host wins that cycle and starve_cnt clears.
  - starve_cnt also clears on any host grant or when h_req=0.
- Write lockout in TX:
  - A winning host write gets h_gnt=1 and h_err=1 in the same cycle. ram_en stays 0 in N+1.
  - A host read in TX is serviced normally.
- Transitions:
  - IDLE->TX when tx_active=1 is sampled.
  - TX->IDLE when tx_active=0 is sampled.
  - Arbitration uses the mode registered at the start of the cycle, so a tx_active edge takes effect one cycle later.
  - In-flight commands and tags complete regardless of mode change.
- Simultaneous host write and modem read in IDLE: round-robin decides; the loser keeps requesting and is granted the next cycle.
- Reset mid-operation: outstanding tags are dropped, so no rvalid is issued for pre-reset reads. Requesters must reissue.

Decomposition:
- Shared package: owner encoding (OWN_HOST=0, OWN_MODEM=1), FSM state constants (ST_IDLE, ST_TX), default ADDR_W/DATA_W.
- One sub-module: ram_rd_tag_pipe (parameterised shift register of {valid, owner} producing h_rvalid/m_rvalid).

Test Plan:
- IDLE, host write addr 0x005 data 0xA5, then host read 0x005 -> h_gnt in cycle 0. ram_en=1, ram_we=1, addr 0x005 in cycle 1. Read returns h_rvalid with 0xA5 at cycle +2 (RD_LATENCY=1).
- IDLE, h_req and m_req held continuously for 6 cycles -> grants alternate H,M,H,M,H,M from reset; exactly one gnt per cycle.
- TX, m_req held continuously, host read pending -> modem granted 8 cycles, host granted on the 9th (STARVE_MAX=8), then modem resumes.
- TX, host write 0x010=0x3C -> h_gnt=1 and h_err=1 in the same cycle; ram_we never asserts; a later IDLE read of 0x010 returns the old value.
- tx_active rises in the same cycle as conflicting requests -> that cycle still arbitrates round-robin; modem priority applies from the next cycle.
- Host read granted, reset_n pulsed low in cycle 1 -> all outputs 0 immediately; no h_rvalid after release.
